reg_pipe: RTL

REG_PIPE -- requirements
Module: reg_pipe

---
 rtl/reg_pipe.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/reg_pipe.sv
// ----------------------------------------------------------------------------
// reg_pipe : elastic register pipeline of DEPTH stages, WIDTH bits per word.
//
// Each stage holds a data word and a valid bit. A stage advances when it is
// empty or when the stage downstream of it advances, so bubbles are squeezed
// out while the pipe is stalled. With out_ready held high the pipe moves one
// word per cycle and a word reaches out_valid DEPTH cycles after acceptance.
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset (highest priority)
//   en         : global enable, 0 freezes all state
//   flush      : synchronous discard of every held word (priority over en)
//   in_data    : upstream word
//   in_valid   : upstream word present
//   in_ready   : pipe accepts a word this cycle
//   out_data   : final-stage word
//   out_valid  : final-stage word present
//   out_ready  : downstream accepts a word
//   count      : number of occupied stages (registered)
//
// Build option:
//   REG_PIPE_CLEAR_DATA_EN : when defined, rst and flush also zero every data
//                            register; otherwise only the valid bits clear.
// ----------------------------------------------------------------------------
module reg_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [CW-1:0]    count_r;

    logic [DEPTH-1:0] adv_s;
    logic [DEPTH:0]   up_valid_s;
    logic [WIDTH-1:0] up_data_s [DEPTH];
    logic [DEPTH-1:0] valid_nxt_s;
    logic [DEPTH-1:0] load_s;
    logic             accept_s;
    logic             xfer_s;

    // Advance chain: a stage may take a new word if it is empty or its
    // downstream neighbour is itself advancing (last stage looks at out_ready).
    always_comb begin
        adv_s = {DEPTH{1'b0}};
        adv_s[DEPTH-1] = !valid_r[DEPTH-1] || out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv_s[i] = !valid_r[i] || adv_s[i+1];
        end
    end

    // Upstream view of every stage: index i is what feeds stage i.
    always_comb begin
        up_valid_s   = {valid_r, in_valid};
        up_data_s[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            up_data_s[i] = data_r[i-1];
        end
    end

    // Next valid bits and data-load strobes; an advancing stage fed by an
    // empty upstream becomes a bubble and its data register is left alone.
    always_comb begin
        valid_nxt_s = valid_r;
        load_s      = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (adv_s[i]) begin
                valid_nxt_s[i] = up_valid_s[i];
                load_s[i]      = up_valid_s[i];
            end else begin
                valid_nxt_s[i] = valid_r[i];
                load_s[i]      = 1'b0;
            end
        end
    end

    // Handshake outputs; out_valid is also masked during flush so nothing
    // is handed downstream in the cycle its word is being discarded.
    always_comb begin
        in_ready  = en && !flush && adv_s[0];
        out_valid = en && !flush && valid_r[DEPTH-1];
        out_data  = data_r[DEPTH-1];
        count     = count_r;
        accept_s  = in_valid && in_ready;
        xfer_s    = out_valid && out_ready;
    end

    // Valid bits and occupancy counter: rst over flush over en.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {DEPTH{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (flush) begin
            valid_r <= {DEPTH{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (en) begin
            valid_r <= valid_nxt_s;
            case ({accept_s, xfer_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end else begin
            valid_r <= valid_r;
            count_r <= count_r;
        end
    end

`ifdef REG_PIPE_CLEAR_DATA_EN
    // Stage data registers, zeroed by rst and flush.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= {WIDTH{1'b0}};
            end
        end else if (en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (load_s[i]) begin
                    data_r[i] <= up_data_s[i];
                end
            end
        end
    end
`else
    // Stage data registers, not reset; the valid bits alone mark content.
    always_ff @(posedge clk) begin
        if (!rst && !flush && en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (load_s[i]) begin
                    data_r[i] <= up_data_s[i];
                end
            end
        end
    end
`endif

endmodule
